pcie_sym_stream_gen: RTL and testbench
======================================

Name: pcie_sym_stream_gen

Overview:
Synthesizable, parametrised symbol-stream generator for the demux datapath. It produces the 8-bit control/data symbol stream that feeds the demux:
- COM training burst
- STP (TLP) or SDP (DLLP) framed packets with incrementing payload and END
- periodic SKP ordered sets
- IDL fill

It replaces fixed scripted stimulus with runtime-configurable traffic under valid/ready backpressure. It serves both as the on-chip traffic source and as the bench driver.

Parameters:
COM_LEN, 4, COM symbols per training burst (>=1)
SKP_LEN, 4, SKP symbols per SKP ordered set (>=1)
SKP_INTERVAL, 32, transferred symbols between SKP ordered sets (>=8)
MAX_PAYLOAD, 16, largest payload length accepted; larger requests clamp to this
PLEN_W, 5, width of payload_len (must hold MAX_PAYLOAD)

Ports:
clk  in  1  symbol clock
reset_L  in  1  asynchronous active-low reset
enable  in  1  link enable; rising level starts stream with COM burst
start  in  1  packet request, sampled only in IDLE_FILL
pkt_type  in  1  0 = TLP (STP framed), 1 = DLLP (SDP framed); sampled with start
payload_len  in  PLEN_W  payload byte count; sampled with start
ready  in  1  downstream accepts symbol this cycle
valid  out  1  data holds a symbol
data  out  8  symbol
k_sym  out  1  data is a control symbol (COM/SKP/STP/SDP/END/IDL)
busy  out  1  packet accepted and not yet completed
pkt_done  out  1  one-cycle pulse on cycle END is transferred

Behaviour:
- Symbol codes: COM 8'hBC, SKP 8'h1C, STP 8'hFB, SDP 8'h5C, END 8'hFD, IDL 8'h7C.
- Reset (reset_L low, async): state OFF; valid=0, data=IDL, k_sym=0, busy=0, pkt_done=0; sequence counter=8'h01; symbol-interval counter=0; skp_pending=0.
- Transfer occurs on a rising clk edge with valid && ready. While valid && !ready, data/k_sym hold stable and no counter advances.
- States:
  - OFF: valid=0. enable=1 -> COM_OS; valid=1, data=COM on the next cycle.
  - COM_OS: emits COM_LEN COMs -> IDLE_FILL.
  - IDLE_FILL: emits IDL continuously.
  - PKT_SOF: emits STP (type 0) or SDP (type 1).
  - PKT_PAY: emits payload bytes.
  - PKT_EOF: emits END.
  - SKP_OS: emits SKP_LEN SKPs -> IDLE_FILL.
- Packet acceptance: in IDLE_FILL, start=1 on a transfer cycle latches pkt_type and len = min(payload_len, MAX_PAYLOAD), and sets busy=1. The next symbol is SOF.
  - len=0: SOF then END directly.
  - start outside IDLE_FILL is ignored; there is no queuing.
- Payload: byte value = sequence counter, which increments by 1 per payload transfer and wraps 8'hFF -> 8'h00. k_sym=0 only for payload bytes.
- PKT_EOF: END transfer pulses pkt_done, clears busy -> SKP_OS if skp_pending, else IDLE_FILL.
- SKP scheduling:
  - The interval counter counts every transfer outside SKP_OS.
  - On reaching SKP_INTERVAL it sets skp_pending and resets to 0.
  - With skp_pending set, the generator enters SKP_OS at the next symbol boundary in IDLE_FILL, or directly after END. It never enters mid-packet.
  - skp_pending clears on the first SKP transfer.
  - skp_pending and start in the same IDLE_FILL cycle: the SKP OS goes first; start is ignored that cycle.
- enable deassert:
  - Mid-packet or mid-OS: the current packet/OS completes.
  - From IDLE_FILL: the current IDL symbol transfers.
  - Then -> OFF, valid=0.
  - Re-enable restarts with a COM burst; the sequence counter is not reset.
- Mid-operation reset: immediate return to reset values; no partial packet completes.
- Latency: enable high -> first COM valid 1 cycle later; start accepted -> SOF on the following transfer slot.

Decomposition:
- Shared package pcie_sym_pkg: symbol constants (COM, SKP, STP, SDP, END, IDL) and the state enum. The demux and the checker reuse it.
- One natural sub-module, sym_interval_cnt: SKP interval counter with pending flag.

Test Plan:
1. Reset release, enable=1, ready=1 -> COM x4, then IDL stream; valid=1 from cycle after enable; k_sym=1 throughout.
2. start, pkt_type=0, payload_len=2 in IDLE_FILL -> STP, 8'h01, 8'h02, END; pkt_done pulses on END; busy high from accept to END.
3. pkt_type=1, payload_len=0 -> SDP, END; then payload_len=31 (clamped to 16) -> SDP, 8'h03..8'h12, END.
4. SKP_INTERVAL=32 with a 10-byte TLP straddling the interval boundary -> SKP x4 emitted immediately after END, never inside the packet; a start held during the SKP cycles is accepted only after return to IDLE_FILL.
5. ready toggled 0/1 pseudo-randomly during a TLP -> identical symbol sequence to the ready=1 case; data stable during every stall.
6. reset_L pulsed low mid-payload, and enable dropped mid-packet in a separate run -> reset: valid=0 immediately, sequence restarts at 8'h01. Enable drop: packet finishes with END, then valid=0; re-enable gives COM x4 and payload continues from the prior counter.

Source files
------------

// File: rtl/pcie_sym_pkg.sv
// Shared symbol definitions for the PCIe symbol-stream path.
// The generator, the demux and the stream checker all import this package
// so that symbol codes and state encodings stay in one place.
package pcie_sym_pkg;

    // Control symbol codes carried with k_sym=1
    localparam logic [7:0] SYM_COM = 8'hBC;
    localparam logic [7:0] SYM_SKP = 8'h1C;
    localparam logic [7:0] SYM_STP = 8'hFB;
    localparam logic [7:0] SYM_SDP = 8'h5C;
    localparam logic [7:0] SYM_END = 8'hFD;
    localparam logic [7:0] SYM_IDL = 8'h7C;

    // Generator states; the state names the symbol currently presented
    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_COM_OS    = 3'd1,
        ST_IDLE_FILL = 3'd2,
        ST_PKT_SOF   = 3'd3,
        ST_PKT_PAY   = 3'd4,
        ST_PKT_EOF   = 3'd5,
        ST_SKP_OS    = 3'd6
    } gen_state_e;

    // Start-of-frame symbol for a packet type: 0 = TLP (STP), 1 = DLLP (SDP)
    function automatic logic [7:0] sof_sym(input logic is_dllp);
        logic [7:0] sym;
        if (is_dllp) begin
            sym = SYM_SDP;
        end else begin
            sym = SYM_STP;
        end
        return sym;
    endfunction

    // True when a byte is one of the defined control symbol codes
    function automatic logic is_ctrl_code(input logic [7:0] sym);
        logic hit;
        case (sym)
            SYM_COM, SYM_SKP, SYM_STP, SYM_SDP, SYM_END, SYM_IDL: hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/sym_interval_cnt.sv
// SKP scheduling counter.
// Counts transferred symbols outside SKP ordered sets; every SKP_INTERVAL of
// them raises a pending flag that stays up until the first SKP is transferred.
// skp_due also reflects a wrap happening on the current transfer, so the
// generator can schedule the SKP OS as the very next symbol.
module sym_interval_cnt
    import pcie_sym_pkg::*;
#(
    parameter int SKP_INTERVAL = 32
) (
    input  logic clk,
    input  logic reset_L,
    input  logic count_en,
    input  logic pend_clr,
    output logic skp_due
);

    localparam int                CNT_W    = $clog2(SKP_INTERVAL);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(SKP_INTERVAL - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             pending_r;
    logic             wrap_s;

    // Detect the transfer that completes an interval
    always_comb begin
        wrap_s  = 1'b0;
        skp_due = 1'b0;
        if (count_en && (cnt_r == LAST_CNT)) begin
            wrap_s = 1'b1;
        end else begin
            wrap_s = 1'b0;
        end
        skp_due = pending_r | wrap_s;
    end

    // Interval counter and pending flag; a wrap takes priority over a clear
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt_r     <= {CNT_W{1'b0}};
            pending_r <= 1'b0;
        end else begin
            if (count_en) begin
                if (wrap_s) begin
                    cnt_r <= {CNT_W{1'b0}};
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end
            if (wrap_s) begin
                pending_r <= 1'b1;
            end else if (pend_clr) begin
                pending_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pcie_sym_stream_gen.sv
// PCIe symbol-stream generator feeding the demux datapath.
// Emits a COM training burst on enable, then IDL fill, framed STP/SDP packets
// with an incrementing payload byte, and periodic SKP ordered sets, all under
// valid/ready flow control. data/k_sym/valid are registered and only change
// on a transfer (or on enable from OFF), so a stalled symbol is held stable.
module pcie_sym_stream_gen
    import pcie_sym_pkg::*;
#(
    parameter int COM_LEN      = 4,
    parameter int SKP_LEN      = 4,
    parameter int SKP_INTERVAL = 32,
    parameter int MAX_PAYLOAD  = 16,
    parameter int PLEN_W       = 5
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              enable,
    input  logic              start,
    input  logic              pkt_type,
    input  logic [PLEN_W-1:0] payload_len,
    input  logic              ready,
    output logic              valid,
    output logic [7:0]        data,
    output logic              k_sym,
    output logic              busy,
    output logic              pkt_done
);

    // One counter serves both ordered-set kinds; size it for the longer one
    localparam int OS_MAX = (COM_LEN > SKP_LEN) ? COM_LEN : SKP_LEN;
    localparam int OS_W   = $clog2(OS_MAX + 1);

    localparam logic [PLEN_W-1:0] MAX_LEN = PLEN_W'(MAX_PAYLOAD);

    gen_state_e        state_r;
    logic              valid_r;
    logic [7:0]        data_r;
    logic              k_sym_r;
    logic              busy_r;
    logic              pkt_done_r;
    logic [7:0]        seq_r;
    logic [OS_W-1:0]   os_cnt_r;
    logic [PLEN_W-1:0] pay_cnt_r;
    logic [PLEN_W-1:0] len_r;

    logic              xfer_s;
    logic              cnt_en_s;
    logic              pend_clr_s;
    logic              skp_due_s;
    logic [PLEN_W-1:0] len_clamped_s;

    gen_state_e        bnd_state_s;
    logic              bnd_valid_s;
    logic [7:0]        bnd_data_s;
    logic              bnd_k_s;

    assign valid    = valid_r;
    assign data     = data_r;
    assign k_sym    = k_sym_r;
    assign busy     = busy_r;
    assign pkt_done = pkt_done_r;

    // Transfer qualification and SKP counter controls
    always_comb begin
        xfer_s     = 1'b0;
        cnt_en_s   = 1'b0;
        pend_clr_s = 1'b0;
        xfer_s = valid_r & ready;
        if (state_r == ST_SKP_OS) begin
            cnt_en_s   = 1'b0;
            pend_clr_s = xfer_s;
        end else begin
            cnt_en_s   = xfer_s;
            pend_clr_s = 1'b0;
        end
    end

    // Requested payload length clamped to the largest supported size
    always_comb begin
        len_clamped_s = payload_len;
        if (payload_len > MAX_LEN) begin
            len_clamped_s = MAX_LEN;
        end else begin
            len_clamped_s = payload_len;
        end
    end

    // Next symbol at a boundary (end of an ordered set, END, or any IDL):
    // stop if disabled, else a due SKP OS, else a packet start (IDL only), else IDL
    always_comb begin
        bnd_state_s = ST_IDLE_FILL;
        bnd_valid_s = 1'b1;
        bnd_data_s  = SYM_IDL;
        bnd_k_s     = 1'b1;
        if (!enable) begin
            bnd_state_s = ST_OFF;
            bnd_valid_s = 1'b0;
            bnd_data_s  = SYM_IDL;
            bnd_k_s     = 1'b0;
        end else if (skp_due_s) begin
            bnd_state_s = ST_SKP_OS;
            bnd_data_s  = SYM_SKP;
        end else if (start && (state_r == ST_IDLE_FILL)) begin
            bnd_state_s = ST_PKT_SOF;
            bnd_data_s  = sof_sym(pkt_type);
        end else begin
            bnd_state_s = ST_IDLE_FILL;
            bnd_data_s  = SYM_IDL;
        end
    end

    sym_interval_cnt #(
        .SKP_INTERVAL (SKP_INTERVAL)
    ) u_interval (
        .clk      (clk),
        .reset_L  (reset_L),
        .count_en (cnt_en_s),
        .pend_clr (pend_clr_s),
        .skp_due  (skp_due_s)
    );

    // Symbol FSM: each state presents its symbol and advances only on a transfer
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_r    <= ST_OFF;
            valid_r    <= 1'b0;
            data_r     <= SYM_IDL;
            k_sym_r    <= 1'b0;
            busy_r     <= 1'b0;
            pkt_done_r <= 1'b0;
            seq_r      <= 8'h01;
            os_cnt_r   <= {OS_W{1'b0}};
            pay_cnt_r  <= {PLEN_W{1'b0}};
            len_r      <= {PLEN_W{1'b0}};
        end else begin
            pkt_done_r <= 1'b0;
            case (state_r)
                ST_OFF: begin
                    if (enable) begin
                        state_r  <= ST_COM_OS;
                        valid_r  <= 1'b1;
                        data_r   <= SYM_COM;
                        k_sym_r  <= 1'b1;
                        os_cnt_r <= OS_W'(1);
                    end
                end
                ST_COM_OS: begin
                    if (xfer_s) begin
                        if (os_cnt_r == OS_W'(COM_LEN)) begin
                            state_r  <= bnd_state_s;
                            valid_r  <= bnd_valid_s;
                            data_r   <= bnd_data_s;
                            k_sym_r  <= bnd_k_s;
                            os_cnt_r <= OS_W'(1);
                        end else begin
                            os_cnt_r <= os_cnt_r + OS_W'(1);
                        end
                    end
                end
                ST_IDLE_FILL: begin
                    if (xfer_s) begin
                        state_r  <= bnd_state_s;
                        valid_r  <= bnd_valid_s;
                        data_r   <= bnd_data_s;
                        k_sym_r  <= bnd_k_s;
                        os_cnt_r <= OS_W'(1);
                        if (bnd_state_s == ST_PKT_SOF) begin
                            busy_r <= 1'b1;
                            len_r  <= len_clamped_s;
                        end
                    end
                end
                ST_PKT_SOF: begin
                    if (xfer_s) begin
                        if (len_r == {PLEN_W{1'b0}}) begin
                            state_r <= ST_PKT_EOF;
                            data_r  <= SYM_END;
                            k_sym_r <= 1'b1;
                        end else begin
                            state_r   <= ST_PKT_PAY;
                            data_r    <= seq_r;
                            k_sym_r   <= 1'b0;
                            pay_cnt_r <= PLEN_W'(1);
                        end
                    end
                end
                ST_PKT_PAY: begin
                    if (xfer_s) begin
                        seq_r <= seq_r + 8'd1;
                        if (pay_cnt_r == len_r) begin
                            state_r <= ST_PKT_EOF;
                            data_r  <= SYM_END;
                            k_sym_r <= 1'b1;
                        end else begin
                            data_r    <= seq_r + 8'd1;
                            pay_cnt_r <= pay_cnt_r + PLEN_W'(1);
                        end
                    end
                end
                ST_PKT_EOF: begin
                    if (xfer_s) begin
                        busy_r     <= 1'b0;
                        pkt_done_r <= 1'b1;
                        state_r    <= bnd_state_s;
                        valid_r    <= bnd_valid_s;
                        data_r     <= bnd_data_s;
                        k_sym_r    <= bnd_k_s;
                        os_cnt_r   <= OS_W'(1);
                    end
                end
                ST_SKP_OS: begin
                    if (xfer_s) begin
                        if (os_cnt_r == OS_W'(SKP_LEN)) begin
                            state_r  <= bnd_state_s;
                            valid_r  <= bnd_valid_s;
                            data_r   <= bnd_data_s;
                            k_sym_r  <= bnd_k_s;
                            os_cnt_r <= OS_W'(1);
                        end else begin
                            os_cnt_r <= os_cnt_r + OS_W'(1);
                        end
                    end
                end
                default: begin
                    state_r <= ST_OFF;
                    valid_r <= 1'b0;
                    data_r  <= SYM_IDL;
                    k_sym_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcie_sym_stream_gen.sv
// Scoreboard bench for pcie_sym_stream_gen: the stimulus pushes the expected
// {busy,k_sym,data} of every symbol it expects to be transferred; a monitor on
// the falling edge pops on each transfer, checks held symbols during stalls,
// and checks that pkt_done pulses exactly in the cycle after an END transfer.
module tb_pcie_sym_stream_gen;

    localparam logic [7:0] S_COM = 8'hBC;
    localparam logic [7:0] S_SKP = 8'h1C;
    localparam logic [7:0] S_STP = 8'hFB;
    localparam logic [7:0] S_SDP = 8'h5C;
    localparam logic [7:0] S_END = 8'hFD;
    localparam logic [7:0] S_IDL = 8'h7C;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       enable;
    logic       start;
    logic       pkt_type;
    logic [4:0] payload_len;
    logic       ready;
    logic       valid;
    logic [7:0] data;
    logic       k_sym;
    logic       busy;
    logic       pkt_done;

    int         n_total = 0;
    int         n_pass  = 0;
    logic [9:0] exp_q[$];
    logic       exp_done = 1'b0;
    logic [9:0] mon_e;
    logic       mon_end;
    logic [15:0] ready_pat = 16'b1011_0010_1101_0010;
    int         xfers;

    always #5 clk = ~clk;

    pcie_sym_stream_gen #(
        .COM_LEN      (4),
        .SKP_LEN      (4),
        .SKP_INTERVAL (32),
        .MAX_PAYLOAD  (16),
        .PLEN_W       (5)
    ) dut (
        .clk         (clk),
        .reset_L     (reset_L),
        .enable      (enable),
        .start       (start),
        .pkt_type    (pkt_type),
        .payload_len (payload_len),
        .ready       (ready),
        .valid       (valid),
        .data        (data),
        .k_sym       (k_sym),
        .busy        (busy),
        .pkt_done    (pkt_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic k, input logic [7:0] d, input logic b);
        exp_q.push_back({b, k, d});
    endtask

    task automatic push_n(input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) push(1'b1, d, 1'b0);
    endtask

    task automatic idle(input int n);
        push_n(S_IDL, n);
        repeat (n) tick();
    endtask

    // Accepting IDL, SOF, eff payload bytes starting at first, END
    task automatic push_pkt(input logic t, input int eff, input logic [7:0] first);
        push(1'b1, S_IDL, 1'b0);
        push(1'b1, t ? S_SDP : S_STP, 1'b1);
        for (int i = 0; i < eff; i++) push(1'b0, first + 8'(i), 1'b1);
        push(1'b1, S_END, 1'b1);
    endtask

    task automatic pkt(input logic t, input logic [4:0] req, input int eff, input logic [7:0] first);
        push_pkt(t, eff, first);
        start = 1'b1; pkt_type = t; payload_len = req;
        tick();
        start = 1'b0;
        repeat (eff + 2) tick();
    endtask

    // Monitor: pkt_done pulse check, transfer pop/compare, stall hold check
    always @(negedge clk) begin
        chk("pkt_done", {31'd0, pkt_done}, {31'd0, exp_done});
        mon_end = 1'b0;
        if (valid === 1'b1 && ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_symbol: got %0h expected none", {busy, k_sym, data});
            end else begin
                mon_e = exp_q.pop_front();
                chk("symbol", {22'd0, busy, k_sym, data}, {22'd0, mon_e});
                mon_end = (mon_e[8:0] == {1'b1, S_END});
            end
        end else if (valid === 1'b1 && ready === 1'b0 && exp_q.size() != 0) begin
            chk("stall_hold", {22'd0, busy, k_sym, data}, {22'd0, exp_q[0]});
        end
        exp_done = mon_end;
    end

    initial begin
        reset_L = 1'b0; enable = 1'b0; start = 1'b0; pkt_type = 1'b0;
        payload_len = 5'd0; ready = 1'b1;
        repeat (2) tick();
        chk("rst_valid",    {31'd0, valid},    32'd0);
        chk("rst_data",     {24'd0, data},     {24'd0, S_IDL});
        chk("rst_k_sym",    {31'd0, k_sym},    32'd0);
        chk("rst_busy",     {31'd0, busy},     32'd0);
        chk("rst_pkt_done", {31'd0, pkt_done}, 32'd0);
        reset_L = 1'b1;
        tick();
        chk("off_valid", {31'd0, valid}, 32'd0);

        // 1: COM burst one cycle after enable, then IDL fill
        enable = 1'b1;
        tick();
        chk("first_com", {23'd0, valid, k_sym, data}, {23'd0, 1'b1, 1'b1, S_COM});
        push_n(S_COM, 4);
        repeat (4) tick();
        idle(4);

        // 2: TLP with two payload bytes
        pkt(1'b0, 5'd2, 2, 8'h01);
        idle(2);

        // 3: empty DLLP, then SKP OS due in idle, then clamped DLLP
        pkt(1'b1, 5'd0, 0, 8'h00);
        idle(14);
        push_n(S_SKP, 4);
        repeat (4) tick();
        pkt(1'b1, 5'd31, 16, 8'h03);
        idle(3);

        // 4: 10-byte TLP straddles the interval; SKP OS right after END,
        // start held across the SKPs is taken at the following IDL
        pkt(1'b0, 5'd10, 10, 8'h13);
        start = 1'b1; pkt_type = 1'b0; payload_len = 5'd1;
        push_n(S_SKP, 4);
        push_pkt(1'b0, 1, 8'h1D);
        repeat (5) tick();
        start = 1'b0;
        repeat (3) tick();

        // 5: backpressure during a TLP
        push_pkt(1'b0, 4, 8'h1E);
        start = 1'b1; payload_len = 5'd4;
        tick();
        start = 1'b0;
        xfers = 0;
        for (int i = 0; i < 64 && xfers < 6; i++) begin
            ready = ready_pat[i % 16];
            tick();
            if (ready) xfers++;
        end
        ready = 1'b1;
        chk("stall_run_len", xfers, 32'd6);

        // 6a: enable dropped mid-packet; packet completes, then OFF
        push_pkt(1'b0, 3, 8'h22);
        start = 1'b1; payload_len = 5'd3;
        tick();
        start = 1'b0;
        tick();
        enable = 1'b0;
        repeat (4) tick();
        chk("drop_off", {30'd0, valid, busy}, 32'd0);
        chk("drop_done", {31'd0, pkt_done}, 32'd1);
        repeat (2) tick();
        chk("drop_stays_off", {31'd0, valid}, 32'd0);
        enable = 1'b1;
        tick();
        push_n(S_COM, 4);
        repeat (4) tick();
        pkt(1'b0, 5'd2, 2, 8'h25);
        idle(1);

        // 6b: reset mid-payload; sequence restarts at 01
        push(1'b1, S_IDL, 1'b0);
        push(1'b1, S_STP, 1'b1);
        push(1'b0, 8'h27, 1'b1);
        push(1'b0, 8'h28, 1'b1);
        start = 1'b1; payload_len = 5'd5;
        tick();
        start = 1'b0;
        repeat (3) tick();
        reset_L = 1'b0;
        #1;
        chk("midrst_state", {22'd0, valid, busy, k_sym, data}, {22'd0, 3'b000, S_IDL});
        repeat (2) tick();
        reset_L = 1'b1;
        tick();
        push_n(S_COM, 4);
        repeat (4) tick();
        pkt(1'b0, 5'd2, 2, 8'h01);
        idle(2);
        ready = 1'b0;
        repeat (2) tick();
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
